prog_sequencer: RTL and testbench

//  Run-level sequencer wrapped around the single-cycle core. Turns the bench start

---
 rtl/prog_sequencer_pkg.sv | 20 ++
 rtl/prog_sequencer_if.sv | 33 +++
 rtl/prog_sequencer_sat_counter.sv | 36 +++
 rtl/prog_sequencer.sv | 126 ++++++++++++
 tb/tb_prog_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// prog_sequencer_pkg : shared state encoding and default widths
// Rev 1.0
// ============================================================================
package prog_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      LOAD = 3'd2,
      RUN  = 3'd3,
      HALT = 3'd4
   } seq_state_t;

   localparam int unsigned PC_W_DEF  = 10;
   localparam int unsigned CYC_W_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// prog_sequencer_if : run-control bus between bench/core and the sequencer
// Rev 1.0
// ============================================================================
interface prog_sequencer_if
   import prog_sequencer_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned CYC_W = CYC_W_DEF
);
   logic             start;
   logic [1:0]       prog_sel;
   logic             done_instr;
   logic             core_start;
   logic             pc_load;
   logic [PC_W-1:0]  pc_load_val;
   logic             run_en;
   logic             done;
   logic             timeout;
   logic [CYC_W-1:0] cycle_count;

   modport master (
      output start, prog_sel, done_instr,
      input  core_start, pc_load, pc_load_val, run_en, done, timeout, cycle_count
   );

   modport slave (
      input  start, prog_sel, done_instr,
      output core_start, pc_load, pc_load_val, run_en, done, timeout, cycle_count
   );
endinterface
`default_nettype wire

// File: rtl/prog_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : clearable up-counter that sticks at all-ones
// Rev 1.0
// ============================================================================
module sat_counter #(
   parameter int unsigned CYC_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             clr_i,
   input  wire logic             en_i,
   output logic [CYC_W-1:0]      q_o
);
   logic [CYC_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// prog_sequencer : launches a program on the core, watches for halt/timeout
// Rev 1.0
// ============================================================================
module prog_sequencer
   import prog_sequencer_pkg::*;
#(
   parameter int unsigned    PC_W       = PC_W_DEF,
   parameter int unsigned    CYC_W      = CYC_W_DEF,
   parameter logic [PC_W-1:0] BASE0     = 'd0,
   parameter logic [PC_W-1:0] BASE1     = 'd256,
   parameter logic [PC_W-1:0] BASE2     = 'd512,
   parameter int unsigned    MAX_CYCLES = 'hFFFF
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   prog_sequencer_if.slave  bus
);
   // Count value seen during the last RUN cycle allowed by the budget
   localparam logic [CYC_W-1:0] LAST_CNT = CYC_W'(MAX_CYCLES - 1);

   seq_state_t       state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [PC_W-1:0]  pc_val_q, pc_val_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             cnt_clr, cnt_en;
   logic [CYC_W-1:0] cnt;

   function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
      case (sel)
         2'd1:    base_of = BASE1;
         2'd2:    base_of = BASE2;
         default: base_of = BASE0;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      pc_val_d  = pc_val_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      if (bus.start && (state_q != LOAD)) begin
         sel_d = bus.prog_sel;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) state_d = ARM;
         end
         ARM: begin
            if (!bus.start) begin
               state_d  = LOAD;
               pc_val_d = base_of(sel_q);
            end
         end
         LOAD: begin
            state_d = RUN;
            cnt_clr = 1'b1;
         end
         RUN: begin
            // Abort outranks halt; halt outranks the budget check
            if (bus.start) begin
               state_d = ARM;
            end else begin
               cnt_en = 1'b1;
               if (bus.done_instr) begin
                  state_d = HALT;
                  done_d  = 1'b1;
               end else if (cnt == LAST_CNT) begin
                  state_d   = HALT;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end
            end
         end
         HALT: begin
            if (bus.start) state_d = ARM;
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == ARM) && (state_q != ARM)) begin
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         pc_val_q  <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         pc_val_q  <= pc_val_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.CYC_W(CYC_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .q_o   (cnt)
   );

   assign bus.core_start  = (state_q != RUN);
   assign bus.pc_load     = (state_q == LOAD);
   assign bus.run_en      = (state_q == RUN);
   assign bus.pc_load_val = pc_val_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.cycle_count = cnt;
endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// tb_prog_sequencer : directed launches against a spec-level reference model
// Rev 1.0
// ============================================================================
module tb_prog_sequencer;
   import prog_sequencer_pkg::*;

   localparam int MAXC = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   prog_sequencer_if #(.PC_W(10), .CYC_W(16)) bus ();

   prog_sequencer #(.MAX_CYCLES(MAXC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_base(input int s);
      case (s)
         1:       return 256;
         2:       return 512;
         default: return 0;
      endcase
   endfunction

   // Reference model: run phase, selected program, elapsed RUN cycles, flags
   seq_state_t ph      = IDLE;
   int         m_sel   = 0;
   int         m_cnt   = 0;
   int         m_pcv   = 0;
   bit         m_done  = 0;
   bit         m_to    = 0;
   bit         m_valid = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         ph = IDLE; m_sel = 0; m_cnt = 0; m_pcv = 0; m_done = 0; m_to = 0;
         m_valid = 1;
      end else begin
         case (ph)
            LOAD: begin
               m_cnt = 0;
               ph    = RUN;
            end
            ARM: begin
               if (bus.start) m_sel = bus.prog_sel;
               else begin
                  ph    = LOAD;
                  m_pcv = exp_base(m_sel);
               end
            end
            RUN: begin
               if (bus.start) begin
                  ph = ARM; m_sel = bus.prog_sel; m_done = 0; m_to = 0;
               end else begin
                  if (bus.done_instr) begin
                     ph = HALT; m_done = 1;
                  end else if (m_cnt + 1 == MAXC) begin
                     ph = HALT; m_done = 1; m_to = 1;
                  end
                  m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
               end
            end
            default: begin
               if (bus.start) begin
                  ph = ARM; m_sel = bus.prog_sel; m_done = 0; m_to = 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("core_start", 32'(bus.core_start), 32'(ph != RUN));
         chk("pc_load", 32'(bus.pc_load), 32'(ph == LOAD));
         chk("run_en", 32'(bus.run_en), 32'(ph == RUN));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("timeout", 32'(bus.timeout), 32'(m_to));
         chk("cycle_count", 32'(bus.cycle_count), 32'(m_cnt));
         chk("load_run_excl", 32'(bus.pc_load & bus.run_en), 32'd0);
         if (ph == LOAD) chk("pc_load_val", 32'(bus.pc_load_val), 32'(m_pcv));
      end
   end

   // Ends at the negedge where LOAD is visible; earlier/later sel values are decoys
   task automatic launch(input logic [1:0] sel);
      @(negedge clk); bus.start = 1'b1; bus.prog_sel = sel ^ 2'b10;
      @(negedge clk); bus.prog_sel = sel;
      @(negedge clk); bus.start = 1'b0; bus.prog_sel = sel ^ 2'b01;
      @(negedge clk);
   endtask

   task automatic run_for(input int n, input bit di);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         bus.done_instr = (k == n) && di;
      end
      @(negedge clk);
      bus.done_instr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; bus.start = 1'b0; bus.prog_sel = 2'd0; bus.done_instr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_core_start", 32'(bus.core_start), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_run_en", 32'(bus.run_en), 32'd0);
      chk("rst_count", 32'(bus.cycle_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      bus.done_instr = 1'b1;
      @(negedge clk);
      bus.done_instr = 1'b0;
      chk("idle_ignores_done_instr", 32'(bus.done), 32'd0);

      // launch prog 1, halt on 5th RUN cycle
      launch(2'd1);
      chk("l1_pc_load", 32'(bus.pc_load), 32'd1);
      chk("l1_pc_val", 32'(bus.pc_load_val), 32'd256);
      chk("l1_run_en_low", 32'(bus.run_en), 32'd0);
      @(negedge clk);
      chk("l1_run_en", 32'(bus.run_en), 32'd1);
      chk("l1_core_start", 32'(bus.core_start), 32'd0);
      run_for(4, 1'b1);
      chk("l1_done", 32'(bus.done), 32'd1);
      chk("l1_count", 32'(bus.cycle_count), 32'd5);
      chk("l1_timeout", 32'(bus.timeout), 32'd0);

      // budget exhaustion
      launch(2'd2);
      chk("to_pc_val", 32'(bus.pc_load_val), 32'd512);
      run_for(MAXC, 1'b0);
      chk("to_done", 32'(bus.done), 32'd1);
      chk("to_timeout", 32'(bus.timeout), 32'd1);
      chk("to_count", 32'(bus.cycle_count), 32'd8);
      bus.done_instr = 1'b1;
      repeat (2) @(negedge clk);
      bus.done_instr = 1'b0;
      chk("to_hold_done", 32'(bus.done), 32'd1);
      chk("to_hold_count", 32'(bus.cycle_count), 32'd8);

      // done_instr on the last budgeted cycle
      launch(2'd0);
      chk("tie_pc_val", 32'(bus.pc_load_val), 32'd0);
      run_for(MAXC, 1'b1);
      chk("tie_done", 32'(bus.done), 32'd1);
      chk("tie_timeout", 32'(bus.timeout), 32'd0);
      chk("tie_count", 32'(bus.cycle_count), 32'd8);

      // abort on RUN cycle 3 (with done_instr also high), then relaunch prog 3
      launch(2'd1);
      repeat (3) @(negedge clk);
      chk("ab_count_c3", 32'(bus.cycle_count), 32'd2);
      bus.start = 1'b1; bus.done_instr = 1'b1;
      @(negedge clk);
      bus.done_instr = 1'b0;
      chk("ab_done", 32'(bus.done), 32'd0);
      chk("ab_run_en", 32'(bus.run_en), 32'd0);
      chk("ab_core_start", 32'(bus.core_start), 32'd1);
      chk("ab_count_frozen", 32'(bus.cycle_count), 32'd2);
      launch(2'd3);
      chk("re_pc_val", 32'(bus.pc_load_val), 32'd0);
      @(negedge clk);
      chk("re_count_restart", 32'(bus.cycle_count), 32'd0);
      run_for(2, 1'b1);
      chk("re_done", 32'(bus.done), 32'd1);
      chk("re_count", 32'(bus.cycle_count), 32'd3);

      // reset during RUN cycle 2
      launch(2'd2);
      repeat (2) @(negedge clk);
      rst_n = 1'b0; bus.done_instr = 1'b1;
      @(negedge clk);
      chk("mr_run_en", 32'(bus.run_en), 32'd0);
      chk("mr_core_start", 32'(bus.core_start), 32'd1);
      chk("mr_done", 32'(bus.done), 32'd0);
      chk("mr_count", 32'(bus.cycle_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_idle_done", 32'(bus.done), 32'd0);
      bus.done_instr = 1'b0;

      // recovery launch after reset
      launch(2'd1);
      chk("rc_pc_val", 32'(bus.pc_load_val), 32'd256);
      run_for(1, 1'b1);
      chk("rc_count", 32'(bus.cycle_count), 32'd1);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
